// File: rtl/core_data_responder_if.sv
// Avalon-MM pipelined bus between a NIOS data master and core_data_responder.
// The master drives requests; the slave answers with waitrequest and read responses.
interface core_data_responder_if;
    logic [19:0] s_address;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_writedata;
    logic [3:0]  s_byteenable;
    logic        s_burstcount;
    logic        s_debugaccess;
    logic        s_waitrequest;
    logic [31:0] s_readdata;
    logic        s_readdatavalid;

    modport master (
        output s_address, s_read, s_write, s_writedata, s_byteenable,
               s_burstcount, s_debugaccess,
        input  s_waitrequest, s_readdata, s_readdatavalid
    );

    modport slave (
        input  s_address, s_read, s_write, s_writedata, s_byteenable,
               s_burstcount, s_debugaccess,
        output s_waitrequest, s_readdata, s_readdatavalid
    );
endinterface

// File: rtl/core_data_responder.sv
// Avalon-MM pipelined slave with a local word RAM, fixed read latency,
// bounded outstanding reads and a sticky decode/protocol error flag.
module core_data_responder #(
    parameter int          MEM_WORDS_LOG2 = 10,
    parameter int          READ_LATENCY   = 2,
    parameter int          MAX_PENDING    = 4,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    core_data_responder_if.slave  s,
    output logic                  err_decode,
    input  logic                  err_clear
);

    localparam int PCNT_W = $clog2(MAX_PENDING + 1);
    localparam int WORDS  = 2 ** MEM_WORDS_LOG2;

    logic [31:0]               mem [WORDS];
    logic [MEM_WORDS_LOG2-1:0] word_idx;
    logic                      in_window;
    logic                      accept;
    logic                      rd_fire;
    logic                      wr_fire;
    logic [31:0]               rd_word;
    logic                      err_set;
    logic                      err_next;
    logic [PCNT_W-1:0]         pending;
    logic [PCNT_W-1:0]         pending_next;
    logic [READ_LATENCY-1:0]   stage_valid;
    logic [31:0]               stage_data [READ_LATENCY];
    logic                      unused_bits;

    assign unused_bits = ^{s.s_debugaccess, s.s_address[1:0]};

    // Back-pressure depends only on registered state (and reset), never on the request.
    assign s.s_waitrequest = !reset_reset_n || (pending == PCNT_W'(MAX_PENDING));

    assign in_window = (s.s_address[19:MEM_WORDS_LOG2+2] == '0);
    assign word_idx  = s.s_address[MEM_WORDS_LOG2+1:2];
    assign accept    = (s.s_read || s.s_write) && !s.s_waitrequest;
    assign rd_fire   = accept && s.s_read && !s.s_write;
    assign wr_fire   = accept && s.s_write && in_window;
    assign rd_word   = in_window ? mem[word_idx] : ERR_DATA;

    assign err_set   = accept && (!in_window || (s.s_read && s.s_write) || (s.s_burstcount == 1'b0));

    // RAM is not reset so contents survive a reset pulse.
    always_ff @(posedge clk_clk) begin
        if (wr_fire) begin
            for (int b = 0; b < 4; b++) begin
                if (s.s_byteenable[b]) begin
                    mem[word_idx][8*b +: 8] <= s.s_writedata[8*b +: 8];
                end
            end
        end
    end

    // Read data is captured at acceptance, so a write from the previous cycle is already visible.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            stage_valid <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                stage_data[k] <= '0;
            end
        end else begin
            stage_valid[0] <= rd_fire;
            if (rd_fire) begin
                stage_data[0] <= rd_word;
            end
            for (int k = 1; k < READ_LATENCY; k++) begin
                stage_valid[k] <= stage_valid[k-1];
                if (stage_valid[k-1]) begin
                    stage_data[k] <= stage_data[k-1];
                end
            end
        end
    end

    assign s.s_readdatavalid = stage_valid[READ_LATENCY-1];
    assign s.s_readdata      = stage_data[READ_LATENCY-1];

    always_comb begin
        pending_next = pending;
        if (rd_fire && !s.s_readdatavalid) begin
            pending_next = pending + 1'b1;
        end else if (!rd_fire && s.s_readdatavalid && (pending != '0)) begin
            pending_next = pending - 1'b1;
        end
    end

    always_comb begin
        err_next = err_decode;
        if (err_set) begin
            err_next = 1'b1;
        end else if (err_clear) begin
            err_next = 1'b0;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            pending    <= '0;
            err_decode <= 1'b0;
        end else begin
            pending    <= pending_next;
            err_decode <= err_next;
        end
    end

endmodule

// File: tb/tb_core_data_responder.sv
// Scoreboard bench for core_data_responder: a default instance plus a
// MAX_PENDING=1 instance to exercise waitrequest throttling.
module tb_core_data_responder;

    localparam int          MEM_LOG2 = 10;
    localparam int          RD_LAT   = 2;
    localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk_clk;
    logic reset_reset_n;
    logic err_clear;
    logic err_decode;
    logic err_clear2;
    logic err_decode2;

    core_data_responder_if bus();
    core_data_responder_if bus2();

    core_data_responder #(
        .MEM_WORDS_LOG2(MEM_LOG2), .READ_LATENCY(RD_LAT), .MAX_PENDING(4), .ERR_DATA(ERR_WORD)
    ) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .s(bus),
        .err_decode(err_decode), .err_clear(err_clear)
    );

    core_data_responder #(
        .MEM_WORDS_LOG2(MEM_LOG2), .READ_LATENCY(RD_LAT), .MAX_PENDING(1), .ERR_DATA(ERR_WORD)
    ) dut2 (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .s(bus2),
        .err_decode(err_decode2), .err_clear(err_clear2)
    );

    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    int          stall_count = 0;
    int          stall_count2 = 0;
    logic        burst_val = 1'b1;
    exp_t        exp_q[$];
    exp_t        exp_q2[$];
    logic [31:0] model_mem [2**MEM_LOG2];

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    always @(posedge clk_clk) cycle <= cycle + 1;

    // Response monitors: each valid must match the oldest expectation in data and cycle.
    always @(negedge clk_clk) begin
        exp_t e;
        if (bus.s_readdatavalid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL dut1_unexpected_valid: got data=%h at cycle %0d, wanted no response", bus.s_readdata, cycle);
            end else begin
                e = exp_q.pop_front();
                if (bus.s_readdata !== e.data || cycle != e.due) begin
                    errors++;
                    $display("[TB] FAIL dut1_read: got %h at cycle %0d, wanted %h at cycle %0d", bus.s_readdata, cycle, e.data, e.due);
                end
            end
        end else if (exp_q.size() > 0 && cycle > exp_q[0].due) begin
            checks++;
            errors++;
            $display("[TB] FAIL dut1_missing_valid: none at cycle %0d, wanted %h at cycle %0d", cycle, exp_q[0].data, exp_q[0].due);
            void'(exp_q.pop_front());
        end
    end

    always @(negedge clk_clk) begin
        exp_t e;
        if (bus2.s_readdatavalid === 1'b1) begin
            checks++;
            if (exp_q2.size() == 0) begin
                errors++;
                $display("[TB] FAIL dut2_unexpected_valid: got data=%h at cycle %0d, wanted no response", bus2.s_readdata, cycle);
            end else begin
                e = exp_q2.pop_front();
                if (bus2.s_readdata !== e.data || cycle != e.due) begin
                    errors++;
                    $display("[TB] FAIL dut2_read: got %h at cycle %0d, wanted %h at cycle %0d", bus2.s_readdata, cycle, e.data, e.due);
                end
            end
        end else if (exp_q2.size() > 0 && cycle > exp_q2[0].due) begin
            checks++;
            errors++;
            $display("[TB] FAIL dut2_missing_valid: none at cycle %0d, wanted %h at cycle %0d", cycle, exp_q2[0].data, exp_q2[0].due);
            void'(exp_q2.pop_front());
        end
    end

    function automatic logic [31:0] model_read(input logic [19:0] a);
        if ((a >> (MEM_LOG2 + 2)) != 0) return ERR_WORD;
        return model_mem[a[MEM_LOG2+1:2]];
    endfunction

    function automatic void model_write(input logic [19:0] a, input logic [31:0] d, input logic [3:0] be);
        if ((a >> (MEM_LOG2 + 2)) == 0) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) model_mem[a[MEM_LOG2+1:2]][8*b +: 8] = d[8*b +: 8];
            end
        end
    endfunction

    task automatic bus_idle();
        @(negedge clk_clk);
        bus.s_read  = 1'b0;
        bus.s_write = 1'b0;
        bus2.s_read  = 1'b0;
        bus2.s_write = 1'b0;
    endtask

    // Request tasks leave the request asserted; the caller issues more or calls bus_idle.
    task automatic issue_read(input logic [19:0] a);
        exp_t e;
        int   w = 0;
        @(negedge clk_clk);
        bus.s_address = a; bus.s_read = 1'b1; bus.s_write = 1'b0;
        bus.s_byteenable = 4'hF; bus.s_burstcount = burst_val;
        #1;
        while (bus.s_waitrequest && w < 40) begin
            stall_count++; @(negedge clk_clk); #1; w++;
        end
        checks++;
        if (bus.s_waitrequest !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dut1_read_accept: waitrequest=%b addr=%h, wanted 0", bus.s_waitrequest, a);
        end else begin
            e.data = model_read(a); e.due = cycle + RD_LAT;
            exp_q.push_back(e);
        end
    endtask

    task automatic issue_write(input logic [19:0] a, input logic [31:0] d, input logic [3:0] be);
        int w = 0;
        @(negedge clk_clk);
        bus.s_address = a; bus.s_read = 1'b0; bus.s_write = 1'b1;
        bus.s_writedata = d; bus.s_byteenable = be; bus.s_burstcount = 1'b1;
        #1;
        while (bus.s_waitrequest && w < 40) begin
            @(negedge clk_clk); #1; w++;
        end
        checks++;
        if (bus.s_waitrequest !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dut1_write_accept: waitrequest=%b addr=%h, wanted 0", bus.s_waitrequest, a);
        end else begin
            model_write(a, d, be);
        end
    endtask

    task automatic issue2_read(input logic [19:0] a, input logic [31:0] expect_data, output int acc_cycle);
        exp_t e;
        int   w = 0;
        @(negedge clk_clk);
        bus2.s_address = a; bus2.s_read = 1'b1; bus2.s_write = 1'b0;
        bus2.s_byteenable = 4'hF; bus2.s_burstcount = 1'b1;
        #1;
        while (bus2.s_waitrequest && w < 40) begin
            stall_count2++; @(negedge clk_clk); #1; w++;
        end
        acc_cycle = cycle;
        checks++;
        if (bus2.s_waitrequest !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dut2_read_accept: waitrequest=%b addr=%h, wanted 0", bus2.s_waitrequest, a);
        end else begin
            e.data = expect_data; e.due = cycle + RD_LAT;
            exp_q2.push_back(e);
        end
    endtask

    task automatic issue2_write(input logic [19:0] a, input logic [31:0] d);
        int w = 0;
        @(negedge clk_clk);
        bus2.s_address = a; bus2.s_read = 1'b0; bus2.s_write = 1'b1;
        bus2.s_writedata = d; bus2.s_byteenable = 4'hF; bus2.s_burstcount = 1'b1;
        #1;
        while (bus2.s_waitrequest && w < 40) begin
            @(negedge clk_clk); #1; w++;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || exp_q2.size() != 0) && n < 30) begin
            @(negedge clk_clk); n++;
        end
        checks++;
        if (exp_q.size() != 0 || exp_q2.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: outstanding=%0d/%0d, wanted 0/0", exp_q.size(), exp_q2.size());
        end
    endtask

    task automatic clear_err();
        @(negedge clk_clk); err_clear = 1'b1;
        @(negedge clk_clk); err_clear = 1'b0;
    endtask

    task automatic test_reset();
        reset_reset_n = 1'b0;
        repeat (3) @(negedge clk_clk);
        #1;
        checks++;
        if (bus.s_waitrequest !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_waitrequest: got %b, wanted 1", bus.s_waitrequest);
        end
        reset_reset_n = 1'b1;
        @(negedge clk_clk); #1;
        checks += 4;
        if (bus.s_readdatavalid !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_valid: got %b, wanted 0", bus.s_readdatavalid);
        end
        if (bus.s_readdata !== 32'h0) begin
            errors++; $display("[TB] FAIL reset_readdata: got %h, wanted 00000000", bus.s_readdata);
        end
        if (err_decode !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_err: got %b, wanted 0", err_decode);
        end
        if (bus.s_waitrequest !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_release_wait: got %b, wanted 0", bus.s_waitrequest);
        end
    endtask

    task automatic test_write_read();
        issue_write(20'h00010, 32'h11223344, 4'b1111);
        issue_read(20'h00010);
        bus_idle();
        wait_drain();
        checks++;
        if (err_decode !== 1'b0) begin
            errors++; $display("[TB] FAIL basic_err: got %b, wanted 0", err_decode);
        end
    endtask

    task automatic test_byte_enable();
        issue_write(20'h00010, 32'hAABBCCDD, 4'b0101);
        issue_read(20'h00010);
        issue_write(20'h00010, 32'h00000000, 4'b0000);
        issue_read(20'h00010);
        bus_idle();
        wait_drain();
        checks++;
        if (model_read(20'h00010) !== 32'h11BB33DD) begin
            errors++; $display("[TB] FAIL be_model: got %h, wanted 11BB33DD", model_read(20'h00010));
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) issue_write(20'h00100 + 20'(4*i), 32'hB0B00000 + 32'(i * 32'h1111), 4'hF);
        stall_count = 0;
        for (int i = 0; i < 8; i++) issue_read(20'h00100 + 20'(4*i));
        bus_idle();
        checks++;
        if (stall_count != 0) begin
            errors++; $display("[TB] FAIL b2b_stalls: got %0d, wanted 0", stall_count);
        end
        wait_drain();
    endtask

    task automatic test_out_of_window();
        clear_err();
        issue_read(20'h80000);
        bus_idle();
        wait_drain();
        checks++;
        if (err_decode !== 1'b1) begin
            errors++; $display("[TB] FAIL oow_err_set: got %b, wanted 1", err_decode);
        end
        repeat (2) @(negedge clk_clk);
        checks++;
        if (err_decode !== 1'b1) begin
            errors++; $display("[TB] FAIL oow_err_sticky: got %b, wanted 1", err_decode);
        end
        clear_err();
        checks++;
        if (err_decode !== 1'b0) begin
            errors++; $display("[TB] FAIL err_clear: got %b, wanted 0", err_decode);
        end
        // Error event and clear in the same cycle: set must win.
        issue_read(20'h80004);
        err_clear = 1'b1;
        @(negedge clk_clk);
        err_clear = 1'b0;
        bus.s_read = 1'b0;
        #1;
        checks++;
        if (err_decode !== 1'b1) begin
            errors++; $display("[TB] FAIL err_set_priority: got %b, wanted 1", err_decode);
        end
        wait_drain();
        clear_err();
        issue_write(20'h80010, 32'h99999999, 4'hF);
        bus_idle();
        checks++;
        if (err_decode !== 1'b1) begin
            errors++; $display("[TB] FAIL oow_write_err: got %b, wanted 1", err_decode);
        end
        issue_read(20'h00010);
        bus_idle();
        wait_drain();
    endtask

    task automatic test_raw_and_collision();
        issue_write(20'h0000C, 32'h00000005, 4'hF);
        issue_read(20'h0000C);
        bus_idle();
        wait_drain();
        clear_err();
        @(negedge clk_clk);
        bus.s_address = 20'h00014; bus.s_read = 1'b1; bus.s_write = 1'b1;
        bus.s_writedata = 32'h00000077; bus.s_byteenable = 4'hF; bus.s_burstcount = 1'b1;
        #1;
        checks++;
        if (bus.s_waitrequest !== 1'b0) begin
            errors++; $display("[TB] FAIL collision_accept: waitrequest=%b, wanted 0", bus.s_waitrequest);
        end else begin
            model_write(20'h00014, 32'h00000077, 4'hF);
        end
        bus_idle();
        repeat (4) @(negedge clk_clk);
        checks++;
        if (err_decode !== 1'b1) begin
            errors++; $display("[TB] FAIL collision_err: got %b, wanted 1", err_decode);
        end
        issue_read(20'h00014);
        bus_idle();
        wait_drain();
    endtask

    task automatic test_burst_zero();
        clear_err();
        burst_val = 1'b0;
        issue_read(20'h00010);
        burst_val = 1'b1;
        bus_idle();
        wait_drain();
        checks++;
        if (err_decode !== 1'b1) begin
            errors++; $display("[TB] FAIL burst0_err: got %b, wanted 1", err_decode);
        end
    endtask

    task automatic test_throttle();
        int acc [4];
        for (int i = 0; i < 4; i++) issue2_write(20'(4*i), 32'h20000000 + 32'(i));
        bus_idle();
        repeat (3) @(negedge clk_clk);
        stall_count2 = 0;
        for (int i = 0; i < 4; i++) issue2_read(20'(4*i), 32'h20000000 + 32'(i), acc[i]);
        bus_idle();
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (acc[i] - acc[i-1] < 2) begin
                errors++; $display("[TB] FAIL throttle_gap%0d: got %0d cycles, wanted >=2", i, acc[i] - acc[i-1]);
            end
        end
        checks++;
        if (stall_count2 == 0) begin
            errors++; $display("[TB] FAIL throttle_wait: got %0d stall cycles, wanted >0", stall_count2);
        end
        wait_drain();
    endtask

    task automatic test_reset_midstream();
        exp_t e;
        issue_write(20'h00020, 32'hCAFEF00D, 4'hF);
        @(negedge clk_clk);
        bus.s_address = 20'h00020; bus.s_read = 1'b1; bus.s_write = 1'b0; bus.s_burstcount = 1'b1;
        bus2.s_address = 20'h00000; bus2.s_read = 1'b1; bus2.s_write = 1'b0; bus2.s_burstcount = 1'b1;
        #1;
        checks++;
        if (bus.s_waitrequest !== 1'b0 || bus2.s_waitrequest !== 1'b0) begin
            errors++; $display("[TB] FAIL midrst_accept: waitrequest=%b/%b, wanted 0/0", bus.s_waitrequest, bus2.s_waitrequest);
        end
        @(negedge clk_clk);
        bus.s_read = 1'b0; bus2.s_read = 1'b0;
        reset_reset_n = 1'b0;
        exp_q.delete(); exp_q2.delete();
        #1;
        checks++;
        if (bus.s_waitrequest !== 1'b1 || bus2.s_waitrequest !== 1'b1) begin
            errors++; $display("[TB] FAIL midrst_wait: waitrequest=%b/%b, wanted 1/1", bus.s_waitrequest, bus2.s_waitrequest);
        end
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        #1;
        checks += 3;
        if (bus.s_readdatavalid !== 1'b0) begin
            errors++; $display("[TB] FAIL midrst_valid: got %b, wanted 0", bus.s_readdatavalid);
        end
        if (bus2.s_waitrequest !== 1'b0) begin
            errors++; $display("[TB] FAIL midrst_pending: dut2 waitrequest=%b, wanted 0", bus2.s_waitrequest);
        end
        if (err_decode !== 1'b0) begin
            errors++; $display("[TB] FAIL midrst_err: got %b, wanted 0", err_decode);
        end
        repeat (5) @(negedge clk_clk);
        issue_read(20'h00020);
        bus_idle();
        wait_drain();
        e.data = 32'h0;
    endtask

    initial begin
        reset_reset_n = 1'b0;
        err_clear = 1'b0;
        err_clear2 = 1'b0;
        bus.s_address = '0; bus.s_read = 1'b0; bus.s_write = 1'b0; bus.s_writedata = '0;
        bus.s_byteenable = 4'hF; bus.s_burstcount = 1'b1; bus.s_debugaccess = 1'b0;
        bus2.s_address = '0; bus2.s_read = 1'b0; bus2.s_write = 1'b0; bus2.s_writedata = '0;
        bus2.s_byteenable = 4'hF; bus2.s_burstcount = 1'b1; bus2.s_debugaccess = 1'b0;
        for (int i = 0; i < 2**MEM_LOG2; i++) model_mem[i] = '0;

        test_reset();
        test_write_read();
        test_byte_enable();
        test_back_to_back();
        test_out_of_window();
        test_raw_and_collision();
        test_burst_zero();
        test_throttle();
        test_reset_midstream();

        repeat (3) @(negedge clk_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
